// File: rtl/vertex_rs_sched_if.sv
// RS/PE-side signal bundle for the Vertex reservation-station slice sequencer.
// master = the sequencer, slave = the RS / PE array environment.
interface vertex_rs_sched_if #(
   parameter int MAX_FV_NUM = 16
);
   localparam int IDX_W = $clog2(MAX_FV_NUM);

   logic             rs_fire;
   logic [IDX_W:0]   cfg_fv_num;
   logic             pe_ready;
   logic             vertex_buf_idle;
   logic [IDX_W-1:0] start_idx;
   logic             slice_valid;
   logic             last_slice;
   logic             complete;

   modport master (
      input  rs_fire, cfg_fv_num, pe_ready, vertex_buf_idle,
      output start_idx, slice_valid, last_slice, complete
   );

   modport slave (
      output rs_fire, cfg_fv_num, pe_ready, vertex_buf_idle,
      input  start_idx, slice_valid, last_slice, complete
   );
endinterface

// File: rtl/vertex_rs_sched.sv
// Steps the RS read window across a feature vector in 2-element slices and hands them to the PEs.
// Optional macro VERTEX_SCHED_PERF_EN adds saturating stall/drain cycle counters.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_IDLE  | waiting for rs_fire
//   ST_LOAD  | one cycle for the RS registered-output latency
//   ST_ISSUE | slice_valid high, advance start_idx on each handshake
//   ST_DRAIN | final slice taken, wait for vertex buffer idle
//   ST_DONE  | one-cycle complete pulse, batch counted
module vertex_rs_sched #(
   parameter int MAX_FV_NUM  = 16,
   parameter int SLICE_W     = 2,
   parameter int BATCH_CNT_W = 8
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_soft_clear,
   vertex_rs_sched_if.master      if_rs,
   output logic                   o_busy,
   output logic [BATCH_CNT_W-1:0] o_batch_cnt
`ifdef VERTEX_SCHED_PERF_EN
   ,
   output logic [15:0]            o_stall_cnt,
   output logic [15:0]            o_drain_cnt
`endif
);
   localparam int IDX_W = $clog2(MAX_FV_NUM);
   localparam int LEN_W = IDX_W + 1;

   typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_ISSUE, ST_DRAIN, ST_DONE} state_t;

   state_t                 r_state, w_state_nxt;
   logic [LEN_W-1:0]       r_len, w_len_nxt, w_len_cfg;
   logic [IDX_W-1:0]       r_start_idx, w_start_nxt;
   logic [BATCH_CNT_W-1:0] r_batch_cnt, w_batch_nxt;
   logic                   r_slice_valid, r_busy, r_complete;
   logic                   w_last_hit;

   // Zero or oversize lengths mean a full vector; odd lengths pad to a whole slice.
   always_comb begin
      w_len_cfg = if_rs.cfg_fv_num;
      if ((if_rs.cfg_fv_num == '0) || (if_rs.cfg_fv_num > LEN_W'(MAX_FV_NUM)))
         w_len_cfg = LEN_W'(MAX_FV_NUM);
      else if (if_rs.cfg_fv_num[0])
         w_len_cfg = if_rs.cfg_fv_num + LEN_W'(1);
   end

   assign w_last_hit = ({1'b0, r_start_idx} == (r_len - LEN_W'(SLICE_W)));

   always_comb begin
      w_state_nxt = r_state;
      w_len_nxt   = r_len;
      w_start_nxt = r_start_idx;
      w_batch_nxt = r_batch_cnt;
      case (r_state)
         ST_IDLE: begin
            if (if_rs.rs_fire) begin
               w_len_nxt   = w_len_cfg;
               w_start_nxt = '0;
               w_state_nxt = ST_LOAD;
            end
         end
         ST_LOAD:  w_state_nxt = ST_ISSUE;
         ST_ISSUE: begin
            if (if_rs.pe_ready) begin
               if (w_last_hit) w_state_nxt = ST_DRAIN;
               else            w_start_nxt = r_start_idx + IDX_W'(SLICE_W);
            end
         end
         ST_DRAIN: begin
            if (if_rs.vertex_buf_idle) begin
               w_state_nxt = ST_DONE;
               w_start_nxt = '0;
               w_batch_nxt = r_batch_cnt + BATCH_CNT_W'(1);
            end
         end
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
      // Abort wins over everything, including a coincident rs_fire.
      if (i_soft_clear) begin
         w_state_nxt = ST_IDLE;
         w_start_nxt = '0;
         w_len_nxt   = r_len;
         w_batch_nxt = r_batch_cnt;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state       <= ST_IDLE;
         r_len         <= '0;
         r_start_idx   <= '0;
         r_batch_cnt   <= '0;
         r_slice_valid <= 1'b0;
         r_busy        <= 1'b0;
         r_complete    <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_len         <= w_len_nxt;
         r_start_idx   <= w_start_nxt;
         r_batch_cnt   <= w_batch_nxt;
         r_slice_valid <= (w_state_nxt == ST_ISSUE);
         r_busy        <= (w_state_nxt != ST_IDLE);
         r_complete    <= (w_state_nxt == ST_DONE);
      end
   end

   assign if_rs.start_idx   = r_start_idx;
   assign if_rs.slice_valid = r_slice_valid;
   assign if_rs.last_slice  = r_slice_valid & w_last_hit;
   assign if_rs.complete    = r_complete;
   assign o_busy            = r_busy;
   assign o_batch_cnt       = r_batch_cnt;

`ifdef VERTEX_SCHED_PERF_EN
   logic [15:0] r_stall_cnt, r_drain_cnt;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_stall_cnt <= '0;
         r_drain_cnt <= '0;
      end else if (i_soft_clear) begin
         r_stall_cnt <= '0;
         r_drain_cnt <= '0;
      end else begin
         if ((r_state == ST_ISSUE) && !if_rs.pe_ready && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
         if ((r_state == ST_DRAIN) && (r_drain_cnt != 16'hFFFF))
            r_drain_cnt <= r_drain_cnt + 16'd1;
      end
   end

   assign o_stall_cnt = r_stall_cnt;
   assign o_drain_cnt = r_drain_cnt;
`endif
endmodule

// File: tb/tb_vertex_rs_sched.sv
// Self-checking bench for vertex_rs_sched: directed scenarios plus randomized batches
// checked against a slice-list/timing model derived from the batch length rules.
module tb_vertex_rs_sched;
   localparam int MAXF  = 16;
   localparam int IDX_W = 4;
   localparam int BCW   = 8;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           soft_clear;
   logic           busy;
   logic [BCW-1:0] batch_cnt;
`ifdef VERTEX_SCHED_PERF_EN
   logic [15:0]    stall_cnt, drain_cnt;
`endif

   vertex_rs_sched_if #(.MAX_FV_NUM(MAXF)) u_if ();

   vertex_rs_sched #(.MAX_FV_NUM(MAXF), .SLICE_W(2), .BATCH_CNT_W(BCW)) dut (
      .i_clk        (clk),
      .i_reset      (rst_n),
      .i_soft_clear (soft_clear),
      .if_rs        (u_if.master),
      .o_busy       (busy),
      .o_batch_cnt  (batch_cnt)
`ifdef VERTEX_SCHED_PERF_EN
      ,
      .o_stall_cnt  (stall_cnt),
      .o_drain_cnt  (drain_cnt)
`endif
   );

   always #5 clk = ~clk;

   int             n_checks = 0;
   int             n_fail   = 0;
   logic [BCW-1:0] exp_batch = '0;
   int             exp_stall = 0;
   int             exp_drain = 0;

   // One batch: fire, LOAD, slices (with optional stalls), drain wait, complete.
   task automatic do_batch(input int cfg, input int stall_slice, input int stall_len,
                           input int drain_wait, input bit rand_stall, input bit fire_in_drain);
      int l, n, s, cyc, tot, exp_cyc;
      bit seen;
      l   = (cfg == 0 || cfg > MAXF) ? MAXF : ((cfg + 1) / 2) * 2;
      n   = l / 2;
      tot = 0;
      cyc = 0;
      u_if.rs_fire = 1'b1; u_if.cfg_fv_num = 5'(cfg);
      u_if.pe_ready = 1'b1; u_if.vertex_buf_idle = 1'b1;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || u_if.slice_valid !== 1'b0) begin
         n_fail++; $display("FAIL idle_before_fire cfg=%0d busy=%b valid=%b want 0/0", cfg, busy, u_if.slice_valid);
      end
      @(posedge clk); #1; cyc++;
      u_if.rs_fire = 1'b0; u_if.cfg_fv_num = 5'($urandom);
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || u_if.slice_valid !== 1'b0) begin
         n_fail++; $display("FAIL load_cycle cfg=%0d busy=%b valid=%b want 1/0", cfg, busy, u_if.slice_valid);
      end
      @(posedge clk); #1; cyc++;
      for (int k = 0; k < n; k++) begin
         s = (k == stall_slice) ? stall_len : (rand_stall ? int'($urandom_range(0, 2)) : 0);
         for (int j = 0; j <= s; j++) begin
            u_if.pe_ready = (j == s);
            u_if.vertex_buf_idle = 1'($urandom);
            @(negedge clk);
            n_checks++;
            if (u_if.slice_valid !== 1'b1 || u_if.start_idx !== 4'(2 * k) ||
                u_if.last_slice !== (k == n - 1)) begin
               n_fail++;
               $display("FAIL slice cfg=%0d k=%0d valid=%b idx=%0d last=%b want 1/%0d/%b",
                        cfg, k, u_if.slice_valid, u_if.start_idx, u_if.last_slice, 2 * k, (k == n - 1));
            end
            @(posedge clk); #1; cyc++;
         end
         tot += s;
      end
      for (int d = 0; d <= drain_wait; d++) begin
         u_if.vertex_buf_idle = (d == drain_wait);
         u_if.pe_ready = 1'($urandom);
         u_if.rs_fire = fire_in_drain && (d == 0);
         @(negedge clk);
         n_checks++;
         if (u_if.slice_valid !== 1'b0 || busy !== 1'b1 || u_if.complete !== 1'b0 ||
             u_if.start_idx !== 4'(2 * (n - 1))) begin
            n_fail++;
            $display("FAIL drain cfg=%0d d=%0d valid=%b busy=%b cpl=%b idx=%0d want 0/1/0/%0d",
                     cfg, d, u_if.slice_valid, busy, u_if.complete, u_if.start_idx, 2 * (n - 1));
         end
         @(posedge clk); #1; cyc++;
         u_if.rs_fire = 1'b0;
      end
      seen = 1'b0;
      for (int t = 0; t < 8 && !seen; t++) begin
         @(negedge clk);
         if (u_if.complete === 1'b1) seen = 1'b1;
         else begin @(posedge clk); #1; cyc++; end
      end
      exp_cyc = n + 3 + tot + drain_wait;
      n_checks++;
      if (!seen) begin
         n_fail++; $display("FAIL complete_timeout cfg=%0d complete never seen, want cycle %0d", cfg, exp_cyc);
      end else if (cyc != exp_cyc) begin
         n_fail++; $display("FAIL complete_cycle cfg=%0d got %0d want %0d", cfg, cyc, exp_cyc);
      end
      if (seen) begin
         exp_batch = exp_batch + 1'b1;
         exp_stall += tot;
         exp_drain += drain_wait + 1;
         n_checks++;
         if (batch_cnt !== exp_batch || u_if.start_idx !== 4'd0 || u_if.slice_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL done_state cfg=%0d batch=%0d idx=%0d valid=%b want %0d/0/0",
                     cfg, batch_cnt, u_if.start_idx, u_if.slice_valid, exp_batch);
         end
`ifdef VERTEX_SCHED_PERF_EN
         n_checks++;
         if (stall_cnt !== 16'(exp_stall) || drain_cnt !== 16'(exp_drain)) begin
            n_fail++;
            $display("FAIL perf_cnt stall=%0d drain=%0d want %0d/%0d", stall_cnt, drain_cnt, exp_stall, exp_drain);
         end
`endif
         @(posedge clk); #1;
         @(negedge clk);
         n_checks++;
         if (busy !== 1'b0 || u_if.complete !== 1'b0) begin
            n_fail++; $display("FAIL after_done cfg=%0d busy=%b cpl=%b want 0/0", cfg, busy, u_if.complete);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; soft_clear = 1'b0;
      u_if.rs_fire = 1'b0; u_if.cfg_fv_num = '0; u_if.pe_ready = 1'b0; u_if.vertex_buf_idle = 1'b0;
      #12;
      n_checks++;
      if (busy !== 1'b0 || batch_cnt !== 8'd0 || u_if.start_idx !== 4'd0 || u_if.slice_valid !== 1'b0 ||
          u_if.last_slice !== 1'b0 || u_if.complete !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_values busy=%b batch=%0d idx=%0d valid=%b last=%b cpl=%b want all 0",
                  busy, batch_cnt, u_if.start_idx, u_if.slice_valid, u_if.last_slice, u_if.complete);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || u_if.slice_valid !== 1'b0) begin
         n_fail++; $display("FAIL post_reset_idle busy=%b valid=%b want 0/0", busy, u_if.slice_valid);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      do_batch(8, -1, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_stall();
      do_batch(8, 1, 3, 0, 1'b0, 1'b0);
   endtask

   task automatic test_lengths();
      do_batch(0, -1, 0, 0, 1'b0, 1'b0);
      do_batch(5, -1, 0, 0, 1'b0, 1'b0);
      do_batch(2, -1, 0, 0, 1'b0, 1'b0);
      do_batch(16, -1, 0, 0, 1'b0, 1'b0);
      do_batch(31, -1, 0, 0, 1'b0, 1'b0);
      do_batch(1, -1, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_drain();
      do_batch(8, -1, 0, 4, 1'b0, 1'b1);
   endtask

   task automatic test_soft_clear();
      u_if.rs_fire = 1'b1; u_if.cfg_fv_num = 5'd8; u_if.pe_ready = 1'b1;
      @(posedge clk); #1; u_if.rs_fire = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      @(negedge clk);
      n_checks++;
      if (u_if.start_idx !== 4'd4 || u_if.slice_valid !== 1'b1) begin
         n_fail++; $display("FAIL sc_setup idx=%0d valid=%b want 4/1", u_if.start_idx, u_if.slice_valid);
      end
      soft_clear = 1'b1;
      @(posedge clk); #1; soft_clear = 1'b0;
      exp_stall = 0; exp_drain = 0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || u_if.start_idx !== 4'd0 || u_if.slice_valid !== 1'b0 || u_if.complete !== 1'b0) begin
         n_fail++;
         $display("FAIL sc_abort busy=%b idx=%0d valid=%b cpl=%b want 0/0/0/0",
                  busy, u_if.start_idx, u_if.slice_valid, u_if.complete);
      end
`ifdef VERTEX_SCHED_PERF_EN
      n_checks++;
      if (stall_cnt !== 16'd0 || drain_cnt !== 16'd0) begin
         n_fail++; $display("FAIL sc_perf_clear stall=%0d drain=%0d want 0/0", stall_cnt, drain_cnt);
      end
`endif
      repeat (4) begin
         @(posedge clk); #1;
         @(negedge clk);
         n_checks++;
         if (u_if.complete !== 1'b0 || batch_cnt !== exp_batch) begin
            n_fail++; $display("FAIL sc_no_complete cpl=%b batch=%0d want 0/%0d", u_if.complete, batch_cnt, exp_batch);
         end
      end
      @(posedge clk); #1;
      soft_clear = 1'b1; u_if.rs_fire = 1'b1;
      @(posedge clk); #1;
      soft_clear = 1'b0; u_if.rs_fire = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL sc_fire_dropped busy=%b want 0", busy);
      end
      @(posedge clk); #1;
      do_batch(8, -1, 0, 1, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 20; i++)
         do_batch(int'($urandom_range(0, 31)), -1, 0, int'($urandom_range(0, 4)), 1'b1, 1'($urandom));
   endtask

   task automatic test_async_reset_wrap();
      u_if.rs_fire = 1'b1; u_if.cfg_fv_num = 5'd8; u_if.pe_ready = 1'b0;
      @(posedge clk); #1; u_if.rs_fire = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0 || batch_cnt !== 8'd0 || u_if.start_idx !== 4'd0 || u_if.slice_valid !== 1'b0 ||
          u_if.last_slice !== 1'b0 || u_if.complete !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset busy=%b batch=%0d idx=%0d valid=%b last=%b cpl=%b want all 0",
                  busy, batch_cnt, u_if.start_idx, u_if.slice_valid, u_if.last_slice, u_if.complete);
      end
      exp_batch = '0; exp_stall = 0; exp_drain = 0;
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 256; i++)
         do_batch(int'($urandom_range(1, 4)), -1, 0, 0, 1'b0, 1'b0);
      @(negedge clk);
      n_checks++;
      if (batch_cnt !== 8'd0) begin
         n_fail++; $display("FAIL batch_wrap batch=%0d want 0", batch_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_lengths();
      test_drain();
      test_soft_clear();
      test_random();
      test_async_reset_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/vertex_rs_sched.md
Name: vertex_rs_sched

Overview:
Sequencer for the Vertex reservation station and Vertex PE array.
- After the RS fires a full batch, it steps the RS read window `start_idx` across the feature vector, one 2-element slice at a time.
- Each slice is handed to the Vertex PEs with a valid/ready handshake.
- Once the vertex buffer has drained, it pulses `complete` so the RS accepts the next batch.
- It sits between the RS (`fire` in, `start_idx`/`complete` out) and the Vertex PE/buffer (handshake and idle in).

Parameters:
- MAX_FV_NUM, 16, maximum feature-vector length in elements; power of two, at least 4.
- SLICE_W, 2, elements per slice; fixed stride of `start_idx`.
- BATCH_CNT_W, 8, width of the completed-batch counter.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state immediately, released synchronously to clk.
- rs_fire  input  1  one-cycle pulse from the RS: a batch is loaded and ready.
- cfg_fv_num  input  $clog2(MAX_FV_NUM)+1  feature-vector length for the next batch; sampled only on accepted rs_fire.
- soft_clear  input  1  synchronous abort; highest priority after reset.
- pe_ready  input  1  Vertex PE array accepts the current slice.
- vertex_buf_idle  input  1  vertex buffer has no work outstanding.
- start_idx  output  $clog2(MAX_FV_NUM)  RS slice read offset.
- slice_valid  output  1  current slice on the RS output is valid for the PEs.
- last_slice  output  1  qualifies slice_valid: this is the final slice of the batch.
- busy  output  1  high in any state other than IDLE.
- complete  output  1  one-cycle pulse at batch end; drives RS `RS_empty`.
- batch_cnt  output  BATCH_CNT_W  completed batches, wraps modulo 2^BATCH_CNT_W.

Behaviour:
- Reset values: start_idx=0, slice_valid=0, last_slice=0, busy=0, complete=0, batch_cnt=0; state=IDLE.
- FSM states: IDLE, LOAD, ISSUE, DRAIN, DONE.
- IDLE:
  - rs_fire latches the length into len_q, clears start_idx, and moves to LOAD.
  - rs_fire in any state other than IDLE is ignored.
- Length rules (len_q):
  - cfg_fv_num=0 or cfg_fv_num>MAX_FV_NUM: len_q=MAX_FV_NUM.
  - Odd values round up to the next even value.
  - Number of slices N = len_q/2, from 1 to MAX_FV_NUM/2.
- LOAD: lasts exactly 1 cycle, covering the RS registered-output latency, then moves to ISSUE.
- ISSUE:
  - slice_valid=1.
  - last_slice=1 when start_idx == len_q-2.
  - Handshake is slice_valid & pe_ready. On a non-final handshake, start_idx += 2 next cycle.
  - On the final handshake, go to DRAIN and hold start_idx.
  - While pe_ready=0: hold start_idx and slice_valid; no bubble insertion.
  - With pe_ready held high, slices issue back-to-back, one per cycle.
- DRAIN:
  - slice_valid=0.
  - Wait for vertex_buf_idle=1, sampled no earlier than the first DRAIN cycle.
  - If vertex_buf_idle is already high on entry, move to DONE next cycle.
- DONE: complete=1 for exactly 1 cycle, batch_cnt += 1, start_idx returns to 0, then IDLE.
- Latency: rs_fire to first slice_valid is 2 cycles. With pe_ready always high and vertex_buf_idle high, rs_fire to complete is N+3 cycles.
- soft_clear:
  - From any state, next cycle: IDLE, start_idx=0, slice_valid=0.
  - No complete pulse; batch_cnt unchanged.
  - If soft_clear and rs_fire arrive together, the fire is dropped.
- All outputs are registered except last_slice, which is decoded combinationally from registered start_idx and len_q.
- Asynchronous reset assertion mid-batch: outputs clear immediately, no complete is generated, and len_q clears to 0.
- batch_cnt wraps from all-ones to 0 silently.

Optional Feature:
- Macro: VERTEX_SCHED_PERF_EN.
- When defined, two outputs are added:
  - stall_cnt [15:0]: counts ISSUE cycles with pe_ready=0, saturating at 16'hFFFF.
  - drain_cnt [15:0]: counts DRAIN cycles, saturating.
- Both counters clear on reset and soft_clear only, and accumulate across batches.
- When undefined, neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Length 8, pe_ready=1, idle=1, pulse rs_fire at cycle 0:
  - slice_valid high cycles 2–5, start_idx 0,2,4,6.
  - last_slice only at start_idx 6.
  - complete at cycle 7; batch_cnt=1.
- Length 8, pe_ready low for 3 cycles while start_idx=2: start_idx holds 2 and slice_valid stays high; stall_cnt=3 when the macro is enabled; complete at cycle 10.
- Length sanitising:
  - cfg_fv_num=0 gives 8 slices, start_idx ending at 14 with MAX_FV_NUM=16.
  - cfg_fv_num=5 gives 3 slices: 0,2,4.
  - cfg_fv_num=2 gives 1 slice with last_slice high on the first cycle.
- DRAIN with vertex_buf_idle low for 4 cycles after the final handshake: complete is delayed by 4 cycles; a second rs_fire during DRAIN is ignored.
- soft_clear in ISSUE at start_idx=4: next cycle IDLE, start_idx=0, no complete, batch_cnt unchanged; a subsequent rs_fire completes normally.
- Asynchronous reset deasserted-low mid-ISSUE, between clock edges: outputs zero immediately; after release, 256 batches wrap batch_cnt to 0.
